melody_sequencer: RTL and testbench

// - Upstream stage of the square-wave tone generator. Steps the melody note address
//   (direccion_nota) through NUM_NOTES entries, holding each for its duration, then a gap.
// - Note ROM maps direccion_nota -> frecuencia_de_nota (half-period) for the tone generator.
// - tone_en gates the speaker: low in gaps and when idle, so repeated notes stay audible.
// - Start, stop and loop control come from the board buttons (already debounced).

---
 rtl/melody_pkg.sv | 54 +++++
 rtl/melody_sequencer_if.sv | 29 ++
 rtl/melody_sequencer_duracion_rom.sv | 23 ++
 rtl/melody_sequencer.sv | 135 +++++++++++++
 tb/tb_melody_sequencer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer slice.
//   state_t            : sequencer FSM states (IDLE / PLAY / GAP)
//   ADDR_W_DEF         : default width of the note address
//   DUR_W_DEF          : default width of a duration code
//   DUR_TABLE_LEN      : number of entries in the built-in duration table
//   dur_table_lookup() : duration code (in beat units) for a table index
package melody_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int ADDR_W_DEF    = 5;
  localparam int DUR_W_DEF     = 4;
  localparam int DUR_TABLE_LEN = 25;

  // One entry per melody note, aligned 1:1 with the note-frequency ROM.
  // Units are eighth notes; indices outside the table are handled by the caller.
  function automatic logic [7:0] dur_table_lookup(input int idx);
    logic [7:0] d;
    case (idx)
      0:  d = 8'd3;
      1:  d = 8'd1;
      2:  d = 8'd4;
      3:  d = 8'd4;
      4:  d = 8'd4;
      5:  d = 8'd8;
      6:  d = 8'd2;
      7:  d = 8'd2;
      8:  d = 8'd4;
      9:  d = 8'd4;
      10: d = 8'd2;
      11: d = 8'd2;
      12: d = 8'd4;
      13: d = 8'd8;
      14: d = 8'd3;
      15: d = 8'd1;
      16: d = 8'd4;
      17: d = 8'd4;
      18: d = 8'd4;
      19: d = 8'd8;
      20: d = 8'd2;
      21: d = 8'd2;
      22: d = 8'd4;
      23: d = 8'd4;
      24: d = 8'd8;
      default: d = 8'd1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Control/status bundle between the button front end and the melody sequencer.
//   start, stop, loop_en : button levels (already debounced) into the sequencer
//   direccion_nota       : current note address to the note ROM / tone generator
//   tone_en              : speaker gate, low during gaps and idle
//   busy                 : high whenever the sequencer is not idle
//   done                 : one-cycle pulse when an unlooped melody finishes
// Handshake: there is no valid/ready pair here. All inputs are levels sampled on
// every rising clk edge, and all outputs are registered and valid every cycle.
interface melody_sequencer_if #(
  parameter int ADDR_W = 5
) ();
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W-1:0] direccion_nota;
  logic              tone_en;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, loop_en,
    input  direccion_nota, tone_en, busy, done
  );

  modport slave (
    input  start, stop, loop_en,
    output direccion_nota, tone_en, busy, done
  );
endinterface

// File: rtl/melody_sequencer_duracion_rom.sv
// Duration ROM: maps a note address to its duration code in beat units.
//   addr : note address (ADDR_W bits)
//   dur  : duration code (DUR_W bits); addresses past the melody return 1
module duracion_rom
  import melody_pkg::*;
#(
  parameter int NUM_NOTES = 25,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DUR_W     = DUR_W_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DUR_W-1:0]  dur
);
  logic [7:0] raw;

  always_comb begin
    raw = dur_table_lookup(int'(addr));
    dur = DUR_W'(1);
    if (int'(addr) < NUM_NOTES && int'(addr) < DUR_TABLE_LEN) begin
      dur = raw[DUR_W-1:0];
    end
  end
endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: steps the note address through the melody, holding each note
// for its duration and following it with a silent gap.
//   clk, rst  : clock and synchronous active-high reset
//   bus       : control/status bundle (slave side), see melody_sequencer_if
//   state_dbg : current FSM state
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int BEAT_CYCLES = 3_000_000,
  parameter int GAP_CYCLES  = 600_000,
  parameter int NUM_NOTES   = 25,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DUR_W       = DUR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  melody_sequencer_if.slave    bus,
  output state_t               state_dbg
);
  localparam int CNT_MAX = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0]  BEAT_LAST = CNT_W'(BEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_NOTES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [DUR_W-1:0]  unit_q, unit_d;
  logic              done_q, done_d;
  logic              tone_q, busy_q;

  logic [DUR_W-1:0]  dur_raw;
  logic [DUR_W-1:0]  dur_last;

  duracion_rom #(
    .NUM_NOTES (NUM_NOTES),
    .ADDR_W    (ADDR_W),
    .DUR_W     (DUR_W)
  ) u_dur_rom (
    .addr (addr_q),
    .dur  (dur_raw)
  );

  // A zero duration code plays for one unit, so the last unit index is 0 either way.
  assign dur_last = (dur_raw == '0) ? '0 : dur_raw - DUR_W'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cycle_d = cycle_q + CNT_W'(1);
    unit_d  = unit_q;
    done_d  = 1'b0;

    if (bus.stop) begin
      // stop wins over everything, including a simultaneous start
      state_d = IDLE;
      addr_d  = '0;
      cycle_d = '0;
      unit_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cycle_d = '0;
          unit_d  = '0;
          if (bus.start) begin
            state_d = PLAY;
            addr_d  = '0;
          end
        end
        PLAY: begin
          if (cycle_q == BEAT_LAST) begin
            cycle_d = '0;
            if (unit_q == dur_last) begin
              state_d = GAP;
              unit_d  = '0;
            end else begin
              unit_d = unit_q + DUR_W'(1);
            end
          end
        end
        GAP: begin
          if (cycle_q == GAP_LAST) begin
            cycle_d = '0;
            unit_d  = '0;
            if (addr_q != ADDR_LAST) begin
              state_d = PLAY;
              addr_d  = addr_q + ADDR_W'(1);
            end else if (bus.loop_en) begin
              state_d = PLAY;
              addr_d  = '0;
            end else begin
              state_d = IDLE;
              addr_d  = '0;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          addr_d  = '0;
          cycle_d = '0;
          unit_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cycle_q <= '0;
      unit_q  <= '0;
      done_q  <= 1'b0;
      tone_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cycle_q <= cycle_d;
      unit_q  <= unit_d;
      done_q  <= done_d;
      tone_q  <= (state_d == PLAY);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.direccion_nota = addr_q;
  assign bus.tone_en        = tone_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign state_dbg          = state_q;
endmodule

// File: tb/tb_melody_sequencer.sv
module tb_melody_sequencer;
  import melody_pkg::*;

  logic   clk;
  logic   rst;
  state_t dbg_a;
  state_t dbg_b;

  int n_checks = 0;
  int n_pass   = 0;
  int done_seen;

  logic [5:0] exp_q[$];
  logic [5:0] exp_v;

  melody_sequencer_if #(.ADDR_W(5)) ifa ();
  melody_sequencer_if #(.ADDR_W(5)) ifb ();

  // 25-note instance for timing, stop, ignore and reset tests
  melody_sequencer #(
    .BEAT_CYCLES (4),
    .GAP_CYCLES  (2),
    .NUM_NOTES   (25),
    .ADDR_W      (5),
    .DUR_W       (4)
  ) dut_a (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifa),
    .state_dbg (dbg_a)
  );

  // 3-note instance for finish and loop tests
  melody_sequencer #(
    .BEAT_CYCLES (4),
    .GAP_CYCLES  (2),
    .NUM_NOTES   (3),
    .ADDR_W      (5),
    .DUR_W       (4)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifb),
    .state_dbg (dbg_b)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // expected {addr[4:0], tone_en} trace for the first three notes, starting the
  // cycle after start: 12 tone / 2 gap at 0, 4 / 2 at 1, 16 at 2
  task automatic push_seg(input logic [4:0] addr, input logic tone, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({addr, tone});
  endtask

  task automatic build_trace();
    exp_q.delete();
    push_seg(5'd0, 1'b1, 12);
    push_seg(5'd0, 1'b0, 2);
    push_seg(5'd1, 1'b1, 4);
    push_seg(5'd1, 1'b0, 2);
    push_seg(5'd2, 1'b1, 16);
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_addr"}, 32'(ifa.direccion_nota), 32'd0);
    check({tag, "_tone"}, 32'(ifa.tone_en), 32'd0);
    check({tag, "_busy"}, 32'(ifa.busy), 32'd0);
    check({tag, "_done"}, 32'(ifa.done), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    ifa.start = 1'b0; ifa.stop = 1'b0; ifa.loop_en = 1'b0;
    ifb.start = 1'b0; ifb.stop = 1'b0; ifb.loop_en = 1'b0;

    // reset
    repeat (3) tick();
    check_idle_a("rst_a");
    check("rst_a_state", 32'(dbg_a), 32'(IDLE));
    check("rst_b_busy", 32'(ifb.busy), 32'd0);
    check("rst_b_tone", 32'(ifb.tone_en), 32'd0);
    check("rst_b_state", 32'(dbg_b), 32'(IDLE));
    rst = 1'b0;
    tick();
    check("idle_hold_busy", 32'(ifa.busy), 32'd0);

    // timing of first three notes
    build_trace();
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int i = 0; i < 36; i++) begin
      exp_v = exp_q.pop_front();
      check($sformatf("timing_%0d", i), 32'({ifa.direccion_nota, ifa.tone_en}), 32'(exp_v));
      if (i < 35) tick();
    end
    check("timing_busy", 32'(ifa.busy), 32'd1);
    ifa.stop = 1'b1;
    tick();
    ifa.stop = 1'b0;
    check_idle_a("stop_end");

    // stop during cycle 2 of note 1
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    repeat (15) tick();
    check("pre_stop_addr", 32'(ifa.direccion_nota), 32'd1);
    check("pre_stop_tone", 32'(ifa.tone_en), 32'd1);
    ifa.stop = 1'b1;
    tick();
    ifa.stop = 1'b0;
    check_idle_a("stop_mid");

    // start and stop together while idle
    ifa.start = 1'b1;
    ifa.stop  = 1'b1;
    tick();
    tick();
    check("both_busy", 32'(ifa.busy), 32'd0);
    check("both_tone", 32'(ifa.tone_en), 32'd0);
    ifa.start = 1'b0;
    ifa.stop  = 1'b0;

    // start pulsed during note 1 is ignored
    build_trace();
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    repeat (14) tick();
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int i = 0; i < 15; i++) void'(exp_q.pop_front());
    for (int i = 15; i < 36; i++) begin
      exp_v = exp_q.pop_front();
      check($sformatf("ignore_%0d", i), 32'({ifa.direccion_nota, ifa.tone_en}), 32'(exp_v));
      if (i < 35) tick();
    end

    // reset during the gap after note 2
    tick();
    check("gap_tone", 32'(ifa.tone_en), 32'd0);
    check("gap_busy", 32'(ifa.busy), 32'd1);
    check("gap_addr", 32'(ifa.direccion_nota), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_a("rst_gap");

    // finish without loop, 3 notes
    ifb.loop_en = 1'b0;
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 38; i++) begin
      if (ifb.done) done_seen++;
      if (i == 37) begin
        check("fin_last_busy", 32'(ifb.busy), 32'd1);
        check("fin_last_tone", 32'(ifb.tone_en), 32'd0);
      end
      tick();
    end
    check("fin_early_done", 32'(done_seen), 32'd0);
    check("fin_done", 32'(ifb.done), 32'd1);
    check("fin_busy", 32'(ifb.busy), 32'd0);
    check("fin_tone", 32'(ifb.tone_en), 32'd0);
    check("fin_addr", 32'(ifb.direccion_nota), 32'd0);
    tick();
    check("fin_done_clr", 32'(ifb.done), 32'd0);
    check("fin_tone_hold", 32'(ifb.tone_en), 32'd0);

    // loop, then drop loop_en in the second pass; start held across done
    ifb.loop_en = 1'b1;
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 38; i++) begin
      if (ifb.done) done_seen++;
      tick();
    end
    check("loop_addr", 32'(ifb.direccion_nota), 32'd0);
    check("loop_tone", 32'(ifb.tone_en), 32'd1);
    check("loop_busy", 32'(ifb.busy), 32'd1);
    for (int i = 38; i < 76; i++) begin
      if (ifb.done) done_seen++;
      if (i == 40) ifb.loop_en = 1'b0;
      if (i == 75) ifb.start = 1'b1;
      tick();
    end
    check("loop_no_done", 32'(done_seen), 32'd0);
    check("loop_end_done", 32'(ifb.done), 32'd1);
    check("loop_end_busy", 32'(ifb.busy), 32'd0);
    tick();
    check("restart_busy", 32'(ifb.busy), 32'd1);
    check("restart_tone", 32'(ifb.tone_en), 32'd1);
    check("restart_addr", 32'(ifb.direccion_nota), 32'd0);
    check("restart_done", 32'(ifb.done), 32'd0);
    ifb.start = 1'b0;
    ifb.stop  = 1'b1;
    tick();
    ifb.stop  = 1'b0;
    check("stop_b_busy", 32'(ifb.busy), 32'd0);
    check("stop_b_done", 32'(ifb.done), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
